// File: rtl/fabric_row_sequencer.sv
// fabric_row_sequencer
// ---------------------
// Purpose: front-end controller for the cell fabric's per-row instruction
// chains. One command at a time names a row and a span of instruction memory.
// The span is streamed into that row's instruction chain at one word per
// cycle. The row is then called, and the sequencer waits for its ret. The
// outcome (completion, timeout or bad row) is reported with done/err pulses.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cmd_valid        command offered by the host/scheduler
//   cmd_ready        high only while idle; accept on cmd_valid && cmd_ready
//   cmd_row          target row (rows >= ROWS are rejected with err)
//   cmd_base         first instruction memory address of the span
//   cmd_len          number of instructions (0 is legal, 2^PC_W reads all)
//   imem_rd_en       instruction memory read strobe
//   imem_rd_addr     instruction memory read address
//   imem_rd_data     {hops, addr, data}, valid one cycle after imem_rd_en
//   instr_data_in    per-row instruction payload (row r at slice r)
//   instr_addr_in    per-row in-cell target address
//   instr_hops_in    per-row column hop count
//   instr_en_in      per-row instruction valid
//   call             per-row one-cycle call pulse
//   ret              per-row ret from the fabric (high = row idle)
//   done             one-cycle pulse at command end
//   err              one-cycle pulse with done on timeout or bad row
module fabric_row_sequencer #(
  parameter int ROWS             = 2,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int PC_W             = 10,
  parameter int RET_GUARD        = 4,
  parameter int TIMEOUT          = 1024,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int WORD_W = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [ROW_W-1:0]                   cmd_row,
  input  logic [PC_W-1:0]                    cmd_base,
  input  logic [PC_W:0]                      cmd_len,
  output logic                               imem_rd_en,
  output logic [PC_W-1:0]                    imem_rd_addr,
  input  logic [WORD_W-1:0]                  imem_rd_data,
  output logic [ROWS*INSTR_DATA_WIDTH-1:0]   instr_data_in,
  output logic [ROWS*INSTR_ADDR_WIDTH-1:0]   instr_addr_in,
  output logic [ROWS*INSTR_HOPS_WIDTH-1:0]   instr_hops_in,
  output logic [ROWS-1:0]                    instr_en_in,
  output logic [ROWS-1:0]                    call,
  input  logic [ROWS-1:0]                    ret,
  output logic                               done,
  output logic                               err
);

  localparam int LEN_W = PC_W + 1;
  localparam int GRD_W = (RET_GUARD > 0) ? $clog2(RET_GUARD + 1) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    CALL,
    GUARD,
    WAIT,
    FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               errFlag_q, errFlag_d;
  logic [GRD_W-1:0]   guard_q, guard_d;
  logic [TO_W-1:0]    toCnt_q, toCnt_d;

  // Read-return pipeline: rdValid_q marks a word on imem_rd_data this cycle;
  // instrEn_q/instrWord_q is that word registered onto the row outputs.
  logic               rdValid_q;
  logic               instrEn_q;
  logic [WORD_W-1:0]  instrWord_q;

  logic               retSel;
  logic               guardLast;
  logic               timeoutHit;

  // State, command latches, counters and the read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      errFlag_q   <= 1'b0;
      guard_q     <= '0;
      toCnt_q     <= '0;
      rdValid_q   <= 1'b0;
      instrEn_q   <= 1'b0;
      instrWord_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      errFlag_q   <= errFlag_d;
      guard_q     <= guard_d;
      toCnt_q     <= toCnt_d;
      rdValid_q   <= imem_rd_en;
      instrEn_q   <= rdValid_q;
      // Payload is forced to 0 when no word is presented, so idle chains see 0.
      instrWord_q <= rdValid_q ? imem_rd_data : '0;
    end
  end

  // Fan the single registered word out to the latched row only; a row index
  // outside the fabric matches nothing, so every row stays quiet.
  always_comb begin
    instr_en_in   = '0;
    instr_data_in = '0;
    instr_addr_in = '0;
    instr_hops_in = '0;
    call          = '0;
    retSel        = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == ROW_W'(r)) begin
        instr_en_in[r] = instrEn_q;
        instr_data_in[r*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH] =
          instrWord_q[INSTR_DATA_WIDTH-1:0];
        instr_addr_in[r*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH] =
          instrWord_q[INSTR_DATA_WIDTH +: INSTR_ADDR_WIDTH];
        instr_hops_in[r*INSTR_HOPS_WIDTH +: INSTR_HOPS_WIDTH] =
          instrWord_q[INSTR_DATA_WIDTH + INSTR_ADDR_WIDTH +: INSTR_HOPS_WIDTH];
        call[r] = (state_q == CALL);
        retSel  = ret[r];
      end
    end
  end

  // The guard and timeout counters hold the number of completed GUARD/WAIT
  // cycles before this one, so "+1" is the count including the current cycle.
  always_comb begin
    guardLast  = (32'(guard_q) + 32'd1) >= 32'(RET_GUARD);
    timeoutHit = (TIMEOUT != 0) && ((32'(toCnt_q) + 32'd1) >= 32'(TIMEOUT));
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    errFlag_d    = errFlag_q;
    guard_d      = guard_q;
    toCnt_d      = toCnt_q;
    cmd_ready    = 1'b0;
    imem_rd_en   = 1'b0;
    imem_rd_addr = '0;
    done         = 1'b0;
    err          = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          row_d     = cmd_row;
          addr_d    = cmd_base;
          remain_d  = cmd_len;
          errFlag_d = 1'b0;
          if (32'(cmd_row) >= 32'(ROWS)) begin
            errFlag_d = 1'b1;
            state_d   = FINISH;
          end else if (cmd_len == '0) begin
            state_d = CALL;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        imem_rd_en   = 1'b1;
        imem_rd_addr = addr_q;
        addr_d       = addr_q + PC_W'(1);
        remain_d     = remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end

      // Wait until the last read's word has been registered onto the row.
      DRAIN: begin
        if (!rdValid_q) begin
          state_d = CALL;
        end
      end

      CALL: begin
        guard_d = '0;
        toCnt_d = '0;
        state_d = (RET_GUARD == 0) ? WAIT : GUARD;
      end

      // ret is still high from before the call while it ripples through the
      // busy chain, so it is not looked at here.
      GUARD: begin
        guard_d = guard_q + GRD_W'(1);
        toCnt_d = (toCnt_q == '1) ? toCnt_q : toCnt_q + TO_W'(1);
        if (timeoutHit) begin
          errFlag_d = 1'b1;
          state_d   = FINISH;
        end else if (guardLast) begin
          state_d = WAIT;
        end
      end

      // ret takes priority over a timeout expiring in the same cycle.
      WAIT: begin
        toCnt_d = (toCnt_q == '1) ? toCnt_q : toCnt_q + TO_W'(1);
        if (retSel) begin
          state_d = FINISH;
        end else if (timeoutHit) begin
          errFlag_d = 1'b1;
          state_d   = FINISH;
        end
      end

      FINISH: begin
        done    = 1'b1;
        err     = errFlag_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fabric_row_sequencer.sv
// tb_fabric_row_sequencer
// -----------------------
// Purpose: self-checking bench for fabric_row_sequencer. Commands are issued
// one at a time; for each one the expected per-cycle outputs are derived from
// the command timing rules (read window, word presentation window, call cycle,
// done cycle from ret/timeout arithmetic) and compared every cycle.
// Ports: none (top-level bench).
module tb_fabric_row_sequencer;

  localparam int ROWS = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int HW   = 4;
  localparam int PC_W = 10;
  localparam int RG   = 4;
  localparam int TO   = 16;
  localparam int RW   = 2;
  localparam int WW   = HW + AW + DW;
  localparam int MEMN = 1 << PC_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [RW-1:0]        cmd_row;
  logic [PC_W-1:0]      cmd_base;
  logic [PC_W:0]        cmd_len;
  logic                 imem_rd_en;
  logic [PC_W-1:0]      imem_rd_addr;
  logic [WW-1:0]        imem_rd_data;
  logic [ROWS*DW-1:0]   instr_data_in;
  logic [ROWS*AW-1:0]   instr_addr_in;
  logic [ROWS*HW-1:0]   instr_hops_in;
  logic [ROWS-1:0]      instr_en_in;
  logic [ROWS-1:0]      call;
  logic [ROWS-1:0]      ret;
  logic                 done;
  logic                 err;

  logic [WW-1:0]        mem [MEMN];

  int checks = 0;
  int errors = 0;

  fabric_row_sequencer #(
    .ROWS(ROWS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW),
    .INSTR_HOPS_WIDTH(HW), .PC_W(PC_W), .RET_GUARD(RG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .imem_rd_en(imem_rd_en), .imem_rd_addr(imem_rd_addr),
    .imem_rd_data(imem_rd_data),
    .instr_data_in(instr_data_in), .instr_addr_in(instr_addr_in),
    .instr_hops_in(instr_hops_in), .instr_en_in(instr_en_in),
    .call(call), .ret(ret), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_data <= mem[imem_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Everything idle: what reset (or a finished command) must look like.
  task automatic checkQuiet(input string phase);
    checkOutput({phase, " cmd_ready"}, 128'(cmd_ready), 128'(1));
    checkOutput({phase, " rd_en"},     128'(imem_rd_en), 128'(0));
    checkOutput({phase, " instr_en"},  128'(instr_en_in), 128'(0));
    checkOutput({phase, " instr_data"},128'(instr_data_in), 128'(0));
    checkOutput({phase, " instr_addr"},128'(instr_addr_in), 128'(0));
    checkOutput({phase, " instr_hops"},128'(instr_hops_in), 128'(0));
    checkOutput({phase, " call"},      128'(call), 128'(0));
    checkOutput({phase, " done"},      128'(done), 128'(0));
    checkOutput({phase, " err"},       128'(err), 128'(0));
  endtask

  // Expected outputs in cycle t of a command (t=0 is the accept cycle).
  task automatic compareCycle(input int t, input int row, input int base,
                              input int len, input int tc, input int tDone,
                              input bit errExp);
    bit                 rowOk;
    bit                 eRd;
    logic [ROWS-1:0]    eEn, eCall;
    logic [ROWS*DW-1:0] eData;
    logic [ROWS*AW-1:0] eAddr;
    logic [ROWS*HW-1:0] eHops;
    logic [WW-1:0]      word;
    rowOk = (row < ROWS);
    eRd   = rowOk && (t >= 1) && (t <= len);
    eEn = '0; eCall = '0; eData = '0; eAddr = '0; eHops = '0;
    if (rowOk && (t >= 3) && (t <= len + 2)) begin
      word = mem[(base + t - 3) % MEMN];
      eEn[row] = 1'b1;
      eData[row*DW +: DW] = word[DW-1:0];
      eAddr[row*AW +: AW] = word[DW +: AW];
      eHops[row*HW +: HW] = word[DW+AW +: HW];
    end
    if (rowOk && (t == tc)) eCall[row] = 1'b1;
    checkOutput($sformatf("cmd_ready@T%0d", t), 128'(cmd_ready),
                128'((t == 0) || (t > tDone)));
    checkOutput($sformatf("rd_en@T%0d", t), 128'(imem_rd_en), 128'(eRd));
    if (eRd)
      checkOutput($sformatf("rd_addr@T%0d", t), 128'(imem_rd_addr),
                  128'((base + t - 1) % MEMN));
    checkOutput($sformatf("instr_en@T%0d", t), 128'(instr_en_in), 128'(eEn));
    checkOutput($sformatf("instr_data@T%0d", t), 128'(instr_data_in), 128'(eData));
    checkOutput($sformatf("instr_addr@T%0d", t), 128'(instr_addr_in), 128'(eAddr));
    checkOutput($sformatf("instr_hops@T%0d", t), 128'(instr_hops_in), 128'(eHops));
    checkOutput($sformatf("call@T%0d", t), 128'(call), 128'(eCall));
    checkOutput($sformatf("done@T%0d", t), 128'(done), 128'(t == tDone));
    checkOutput($sformatf("err@T%0d", t), 128'(err), 128'((t == tDone) && errExp));
  endtask

  // One command. ret[row] is low for lowLen cycles right after the call
  // (lowLen=0: held high). abortAt>0 pulls reset in that cycle and returns.
  task automatic applyStimulus(input int row, input int base, input int len,
                               input int lowLen, input int abortAt);
    int tc, tRet, tDone;
    bit errExp;
    if (row >= ROWS) begin
      tc = 0; tDone = 1; errExp = 1'b1;
    end else begin
      tc   = (len == 0) ? 1 : len + 3;
      tRet = tc + 1 + ((lowLen > RG) ? lowLen : RG);
      if (tRet <= tc + TO) begin
        tDone = tRet + 1; errExp = 1'b0;
      end else begin
        tDone = tc + TO + 1; errExp = 1'b1;
      end
    end
    @(negedge clk);
    compareCycle(0, row, base, len, tc, tDone, errExp);
    cmd_valid = 1'b1;
    cmd_row   = RW'(row);
    cmd_base  = PC_W'(base);
    cmd_len   = (PC_W+1)'(len);
    ret       = '1;
    for (int t = 1; t <= tDone + 1; t++) begin
      @(negedge clk);
      compareCycle(t, row, base, len, tc, tDone, errExp);
      if (t == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkQuiet("abort");
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        ret       = '1;
        return;
      end
      // Garbage command traffic while busy must be ignored.
      cmd_valid = (t < tDone) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_row   = RW'($urandom);
      cmd_base  = PC_W'($urandom);
      cmd_len   = (PC_W+1)'($urandom);
      for (int r = 0; r < ROWS; r++) begin
        if (r == row) ret[r] = !((t >= tc + 1) && (t <= tc + lowLen));
        else          ret[r] = 1'($urandom_range(0, 1));
      end
    end
    ret = '1;
  endtask

  initial begin
    int lowSel, lowLen;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_row   = '0;
    cmd_base  = '0;
    cmd_len   = '0;
    ret       = '1;
    for (int i = 0; i < MEMN; i++) mem[i] = {8'($urandom), $urandom};
    mem[16] = {4'h3, 4'h9, 32'hAAAA_0001};
    mem[17] = {4'hC, 4'h5, 32'hBBBB_0002};
    mem[18] = {4'h7, 4'hE, 32'hCCCC_0003};

    repeat (2) @(negedge clk);
    checkQuiet("reset");
    rst_n = 1'b1;

    applyStimulus(1, 'h010, 3, 10, 0);     // basic stream + call + ret
    applyStimulus(0, 'h000, 0, 0, 0);      // len=0, ret held high
    applyStimulus(0, 'h3FE, 4, 2, 0);      // address wrap
    applyStimulus(1, 'h055, 2, 1000, 0);   // ret never rises: timeout
    applyStimulus(0, 'h020, 1, 3, 0);      // normal command after timeout
    applyStimulus(1, 'h030, 0, 15, 0);     // ret in the timeout cycle: ret wins
    applyStimulus(2, 'h030, 0, 16, 0);     // ret one cycle late: timeout
    applyStimulus(3, 'h040, 5, 0, 0);      // bad row
    applyStimulus(1, 'h100, 8, 3, 2);      // reset during LOAD
    applyStimulus(1, 'h100, 8, 3, 0);      // clean run after reset
    applyStimulus(0, 'h200, MEMN, 5, 0);   // full-memory length

    for (int n = 0; n < 15; n++) begin
      lowSel = $urandom_range(0, 3);
      lowLen = (lowSel == 0) ? 0 : (lowSel == 3) ? 1000 : $urandom_range(1, 16);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, MEMN - 1),
                    $urandom_range(0, 20), lowLen, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
